// File: rtl/qei_speed_array_pkg.sv
// Shared configuration defaults, step encoding and x4 decode helper for the
// quadrature speed sampler.
`ifndef CLK_FREQ
`define CLK_FREQ 1000
`endif
`ifndef PID_SPEED_FREQ
`define PID_SPEED_FREQ 100
`endif
`ifndef QEI_RES
`define QEI_RES 16
`endif
`ifndef PID_RES
`define PID_RES 16
`endif

package qei_speed_array_pkg;

    localparam int DEF_CLK_FREQ   = `CLK_FREQ;
    localparam int DEF_SAMPLE_FREQ = `PID_SPEED_FREQ;
    localparam int DEF_QEI_RES    = `QEI_RES;
    localparam int DEF_SPEED_RES  = `PID_RES;

    // Encoded as the modular position delta, so the decode is a subtraction.
    typedef enum logic [1:0] {
        STEP_NONE = 2'd0,
        STEP_UP   = 2'd1,
        STEP_ERR  = 2'd2,
        STEP_DN   = 2'd3
    } step_e;

    // {A,B} maps onto positions 00->0, 01->1, 11->2, 10->3 around the x4 cycle.
    function automatic step_e qei_step(input logic [1:0] prev_ab, input logic [1:0] cur_ab);
        logic [1:0] p_prev;
        logic [1:0] p_cur;
        logic [1:0] delta;
        p_prev = {prev_ab[1], prev_ab[1] ^ prev_ab[0]};
        p_cur  = {cur_ab[1], cur_ab[1] ^ cur_ab[0]};
        delta  = p_cur - p_prev;
        return step_e'(delta);
    endfunction

endpackage

// File: rtl/qei_speed_array_decoder.sv
// One encoder channel: 2-FF synchroniser on A/B plus x4 quadrature decode
// into single-cycle up / down / illegal-transition pulses.
module qei_decoder
    import qei_speed_array_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic a_i,
    input  logic b_i,
    output logic step_up_o,
    output logic step_dn_o,
    output logic err_o
);

    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] prev_q;
    step_e      step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            sync1_q <= {a_i, b_i};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign step      = qei_step(prev_q, sync2_q);
    assign step_up_o = (step == STEP_UP);
    assign step_dn_o = (step == STEP_DN);
    assign err_o     = (step == STEP_ERR);

endmodule

// File: rtl/qei_speed_array.sv
// N-channel quadrature speed sampler: per-window signed counts, optional
// block averaging of 2^AVG_LOG2 windows, saturated speeds with a common strobe.
module qei_speed_array
    import qei_speed_array_pkg::*;
#(
    parameter int CLK_FREQ    = DEF_CLK_FREQ,
    parameter int SAMPLE_FREQ = DEF_SAMPLE_FREQ,
    parameter int N_CH        = 2,
    parameter int QEI_RES     = DEF_QEI_RES,
    parameter int SPEED_RES   = DEF_SPEED_RES,
    parameter int AVG_LOG2    = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      en,
    input  logic [N_CH-1:0]           qeiA_i,
    input  logic [N_CH-1:0]           qeiB_i,
    output logic [N_CH*SPEED_RES-1:0] speed_o,
    output logic                      valid_o,
    output logic [N_CH-1:0]           ovf_o,
    output logic [N_CH-1:0]           err_o
);

    localparam int P  = CLK_FREQ / SAMPLE_FREQ;
    localparam int CW = $clog2(P);
    localparam int IW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int SW = QEI_RES + AVG_LOG2;
    localparam logic signed [QEI_RES:0]   ACC_MAX = (QEI_RES+1)'((1 <<< (QEI_RES-1)) - 1);
    localparam logic signed [QEI_RES-1:0] WIN_MAX = ACC_MAX[QEI_RES-1:0];

    logic [CW-1:0] cnt_q;
    logic [IW-1:0] idx_q;
    logic          valid_q;
    logic          tick;
    logic          last;

    assign tick = en && (cnt_q == CW'(P - 1));
    assign last = (idx_q == IW'((1 << AVG_LOG2) - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (clr) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= tick && last;
            if (tick) begin
                cnt_q <= '0;
                idx_q <= last ? '0 : idx_q + IW'(1);
            end else if (en) begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign valid_o = valid_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic                        up, dn, bad, lost;
        logic signed [QEI_RES-1:0]   acc_q, win;
        logic signed [QEI_RES:0]     inc;
        logic signed [SW-1:0]        sum_q, win_x, sum_in, avg;
        logic signed [SPEED_RES-1:0] spd_q, spd_d;
        logic                        ovf_q, err_q;

        qei_decoder u_dec (
            .clk       (clk),
            .rst       (rst),
            .a_i       (qeiA_i[i]),
            .b_i       (qeiB_i[i]),
            .step_up_o (up),
            .step_dn_o (dn),
            .err_o     (bad)
        );

        // Clamped window value including this cycle's step; on a tick it is
        // what the closing window contributes to the average.
        always_comb begin
            inc = {acc_q[QEI_RES-1], acc_q};
            if (up) inc = inc + (QEI_RES+1)'(1);
            if (dn) inc = inc - (QEI_RES+1)'(1);
            lost = 1'b0;
            win  = inc[QEI_RES-1:0];
            if (inc > ACC_MAX) begin
                win  = WIN_MAX;
                lost = 1'b1;
            end else if (inc < -ACC_MAX) begin
                win  = -WIN_MAX;
                lost = 1'b1;
            end
            win_x  = win;
            sum_in = sum_q + win_x;
            avg    = sum_in >>> AVG_LOG2;
        end

        if (SPEED_RES < QEI_RES) begin : g_sat
            localparam logic signed [SW-1:0] S_MAX = SW'((1 <<< (SPEED_RES-1)) - 1);
            localparam logic signed [SW-1:0] S_MIN = SW'(-(1 <<< (SPEED_RES-1)));
            assign spd_d = (avg > S_MAX) ? SPEED_RES'(S_MAX) :
                           (avg < S_MIN) ? SPEED_RES'(S_MIN) : avg[SPEED_RES-1:0];
        end else begin : g_ext
            assign spd_d = SPEED_RES'(avg);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc_q <= '0;
                sum_q <= '0;
                spd_q <= '0;
                ovf_q <= 1'b0;
                err_q <= 1'b0;
            end else if (clr) begin
                acc_q <= '0;
                sum_q <= '0;
                spd_q <= '0;
                ovf_q <= 1'b0;
                err_q <= 1'b0;
            end else begin
                if (bad) err_q <= 1'b1;
                if (en) begin
                    if (lost) ovf_q <= 1'b1;
                    if (tick) begin
                        acc_q <= '0;
                        if (last) begin
                            sum_q <= '0;
                            spd_q <= spd_d;
                        end else begin
                            sum_q <= sum_in;
                        end
                    end else begin
                        acc_q <= win;
                    end
                end
            end
        end

        assign speed_o[i*SPEED_RES +: SPEED_RES] = spd_q;
        assign ovf_o[i] = ovf_q;
        assign err_o[i] = err_q;
    end

endmodule

// File: tb/tb_qei_speed_array.sv
// Randomised check of four qei_speed_array configurations against a
// position-history reference model of the sampling rules.
module tb_qei_speed_array;

    localparam int P  = 10;
    localparam int NC = 2;
    localparam int ND = 4;

    logic clk = 1'b0;
    logic rst, clr, en;
    logic [NC-1:0] qa, qb;
    logic [31:0] spd0, spd1, spd2;
    logic [7:0]  spd3;
    logic v0, v1, v2, v3;
    logic [NC-1:0] ovf0, ovf1, ovf2, ovf3, err0, err1, err2, err3;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    qei_speed_array #(.CLK_FREQ(1000), .SAMPLE_FREQ(100), .N_CH(NC), .QEI_RES(16), .SPEED_RES(16), .AVG_LOG2(0))
        dut0 (.clk(clk), .rst(rst), .clr(clr), .en(en), .qeiA_i(qa), .qeiB_i(qb),
              .speed_o(spd0), .valid_o(v0), .ovf_o(ovf0), .err_o(err0));
    qei_speed_array #(.CLK_FREQ(1000), .SAMPLE_FREQ(100), .N_CH(NC), .QEI_RES(4), .SPEED_RES(16), .AVG_LOG2(0))
        dut1 (.clk(clk), .rst(rst), .clr(clr), .en(en), .qeiA_i(qa), .qeiB_i(qb),
              .speed_o(spd1), .valid_o(v1), .ovf_o(ovf1), .err_o(err1));
    qei_speed_array #(.CLK_FREQ(1000), .SAMPLE_FREQ(100), .N_CH(NC), .QEI_RES(16), .SPEED_RES(16), .AVG_LOG2(2))
        dut2 (.clk(clk), .rst(rst), .clr(clr), .en(en), .qeiA_i(qa), .qeiB_i(qb),
              .speed_o(spd2), .valid_o(v2), .ovf_o(ovf2), .err_o(err2));
    qei_speed_array #(.CLK_FREQ(1000), .SAMPLE_FREQ(100), .N_CH(NC), .QEI_RES(8), .SPEED_RES(4), .AVG_LOG2(1))
        dut3 (.clk(clk), .rst(rst), .clr(clr), .en(en), .qeiA_i(qa), .qeiB_i(qb),
              .speed_o(spd3), .valid_o(v3), .ovf_o(ovf3), .err_o(err3));

    function automatic int cfg_qr(int c);
        case (c) 0: return 16; 1: return 4; 2: return 16; default: return 8; endcase
    endfunction
    function automatic int cfg_sr(int c);
        return (c == 3) ? 4 : 16;
    endfunction
    function automatic int cfg_al(int c);
        case (c) 2: return 2; 3: return 1; default: return 0; endcase
    endfunction

    function automatic int obs_spd(int c, int ch);
        case (c)
            0: return ch ? int'($signed(spd0[31:16])) : int'($signed(spd0[15:0]));
            1: return ch ? int'($signed(spd1[31:16])) : int'($signed(spd1[15:0]));
            2: return ch ? int'($signed(spd2[31:16])) : int'($signed(spd2[15:0]));
            default: return ch ? int'($signed(spd3[7:4])) : int'($signed(spd3[3:0]));
        endcase
    endfunction
    function automatic int obs_v(int c);
        case (c) 0: return int'(v0); 1: return int'(v1); 2: return int'(v2); default: return int'(v3); endcase
    endfunction
    function automatic int obs_ovf(int c, int ch);
        case (c) 0: return int'(ovf0[ch]); 1: return int'(ovf1[ch]); 2: return int'(ovf2[ch]);
            default: return int'(ovf3[ch]); endcase
    endfunction
    function automatic int obs_err(int c, int ch);
        case (c) 0: return int'(err0[ch]); 1: return int'(err1[ch]); 2: return int'(err2[ch]);
            default: return int'(err3[ch]); endcase
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: shaft positions driven onto the pins, delayed by the
    // synchroniser depth, and the window / averaging rules in plain integers.
    int pos [NC];
    int h1 [NC], h2 [NC], h3 [NC];
    int m_acc [ND][NC], m_sum [ND][NC], m_spd [ND][NC];
    int m_ovf [ND][NC], m_err [ND][NC];
    int m_vld [ND], m_cnt [ND], m_win [ND];

    task automatic model_clear(input int c);
        for (int ch = 0; ch < NC; ch++) begin
            m_acc[c][ch] = 0; m_sum[c][ch] = 0; m_spd[c][ch] = 0;
            m_ovf[c][ch] = 0; m_err[c][ch] = 0;
        end
        m_vld[c] = 0; m_cnt[c] = 0; m_win[c] = 0;
    endtask

    task automatic model_step();
        int d [NC];
        int s, v, lim, r, hi, lo;
        if (rst) begin
            for (int c = 0; c < ND; c++) model_clear(c);
            for (int ch = 0; ch < NC; ch++) begin h1[ch] = 0; h2[ch] = 0; h3[ch] = 0; end
            return;
        end
        for (int ch = 0; ch < NC; ch++) d[ch] = (h2[ch] - h3[ch] + 4) % 4;
        for (int c = 0; c < ND; c++) begin
            m_vld[c] = 0;
            if (clr) begin
                model_clear(c);
                continue;
            end
            for (int ch = 0; ch < NC; ch++) if (d[ch] == 2) m_err[c][ch] = 1;
            if (!en) continue;
            lim = (1 << (cfg_qr(c) - 1)) - 1;
            for (int ch = 0; ch < NC; ch++) begin
                s = (d[ch] == 1) ? 1 : (d[ch] == 3) ? -1 : 0;
                v = m_acc[c][ch] + s;
                if (v > lim) begin v = lim; m_ovf[c][ch] = 1; end
                if (v < -lim) begin v = -lim; m_ovf[c][ch] = 1; end
                if (m_cnt[c] == P - 1) begin
                    m_sum[c][ch] += v;
                    m_acc[c][ch] = 0;
                end else begin
                    m_acc[c][ch] = v;
                end
            end
            if (m_cnt[c] == P - 1) begin
                m_cnt[c] = 0;
                if (m_win[c] == (1 << cfg_al(c)) - 1) begin
                    for (int ch = 0; ch < NC; ch++) begin
                        r = m_sum[c][ch] >>> cfg_al(c);
                        if (cfg_sr(c) < cfg_qr(c)) begin
                            hi = (1 << (cfg_sr(c) - 1)) - 1;
                            lo = -(1 << (cfg_sr(c) - 1));
                            if (r > hi) r = hi;
                            if (r < lo) r = lo;
                        end
                        m_spd[c][ch] = r;
                        m_sum[c][ch] = 0;
                    end
                    m_vld[c] = 1;
                    m_win[c] = 0;
                end else begin
                    m_win[c]++;
                end
            end else begin
                m_cnt[c]++;
            end
        end
        for (int ch = 0; ch < NC; ch++) begin
            h3[ch] = h2[ch]; h2[ch] = h1[ch]; h1[ch] = pos[ch];
        end
    endtask

    task automatic compare();
        for (int c = 0; c < ND; c++) begin
            chk($sformatf("c%0d.valid", c), obs_v(c), m_vld[c]);
            for (int ch = 0; ch < NC; ch++) begin
                chk($sformatf("c%0d.speed%0d", c, ch), obs_spd(c, ch), m_spd[c][ch]);
                chk($sformatf("c%0d.ovf%0d", c, ch), obs_ovf(c, ch), m_ovf[c][ch]);
                chk($sformatf("c%0d.err%0d", c, ch), obs_err(c, ch), m_err[c][ch]);
            end
        end
    endtask

    task automatic drive_pins();
        for (int ch = 0; ch < NC; ch++) begin
            qa[ch] = (pos[ch] == 2) || (pos[ch] == 3);
            qb[ch] = (pos[ch] == 1) || (pos[ch] == 2);
        end
    endtask

    initial begin
        int fwd, rev, r, rst_left, off_left;
        int fwd_tab [5];
        int rev_tab [5];
        fwd_tab = '{40, 95, 0, 30, 10};
        rev_tab = '{20, 0, 95, 30, 10};
        rst = 1'b1; clr = 1'b0; en = 1'b0;
        for (int ch = 0; ch < NC; ch++) pos[ch] = 0;
        drive_pins();
        rst_left = 0; off_left = 0;
        repeat (3) begin
            @(posedge clk); model_step();
            @(negedge clk); compare();
        end
        rst = 1'b0; en = 1'b1;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk); model_step();
            @(negedge clk); compare();
            fwd = fwd_tab[(cyc / 120) % 5];
            rev = rev_tab[(cyc / 120) % 5];
            for (int ch = 0; ch < NC; ch++) begin
                r = $urandom_range(0, 99);
                if (r < 1) pos[ch] = (pos[ch] + 2) % 4;
                else if (r < 1 + fwd) pos[ch] = (pos[ch] + 1) % 4;
                else if (r < 1 + fwd + rev) pos[ch] = (pos[ch] + 3) % 4;
            end
            drive_pins();
            clr = ($urandom_range(0, 249) == 0);
            if (off_left > 0) begin
                off_left--;
                en = 1'b0;
            end else if ($urandom_range(0, 149) == 0) begin
                off_left = 24;
                en = 1'b0;
            end else begin
                en = ($urandom_range(0, 19) != 0);
            end
            if (rst_left > 0) begin
                rst_left--;
                rst = (rst_left > 0);
            end else if ($urandom_range(0, 599) == 0) begin
                rst_left = $urandom_range(1, 3);
                rst = 1'b1;
                #1;
                for (int c = 0; c < ND; c++) begin
                    chk($sformatf("c%0d.rst_valid", c), obs_v(c), 0);
                    for (int ch = 0; ch < NC; ch++) begin
                        chk($sformatf("c%0d.rst_speed%0d", c, ch), obs_spd(c, ch), 0);
                        chk($sformatf("c%0d.rst_ovf%0d", c, ch), obs_ovf(c, ch), 0);
                        chk($sformatf("c%0d.rst_err%0d", c, ch), obs_err(c, ch), 0);
                    end
                end
            end
        end
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule

// File: doc/qei_speed_array.md
# qei_speed_array

Parametrised N-channel quadrature speed sampler for the motor control path. Each channel synchronises and x4-decodes one encoder and accumulates signed counts over a fixed sample window. Optionally it block-averages 2^avg_log2 windows and publishes saturated signed speeds with a common valid strobe. It replaces the fixed two-channel encoder sampling in front of the speed PIDs, and adds error and overflow reporting.

## Interface
- clk_freq, `CLK_FREQ: system clock frequency, Hz
- sample_freq, `PID_SPEED_FREQ: window rate, Hz; period P = floor(clk_freq/sample_freq), P ≥ 2 required
- n_ch, 2: number of encoder channels, ≥ 1
- qei_res, `QEI_RES: per-window accumulator width, signed
- speed_res, `PID_RES: output width per channel, signed
- avg_log2, 0: log2 of the number of windows averaged, 0..4
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- clr  in  1  synchronous clear of all datapath state
- en  in  1  sampling enable
- qeiA_i  in  n_ch  encoder A phase, channel i on bit i, asynchronous
- qeiB_i  in  n_ch  encoder B phase, channel i on bit i, asynchronous
- speed_o  out  n_ch*speed_res  channel i on [i*speed_res +: speed_res], two's complement
- valid_o  out  1  one-cycle pulse when speed_o updates
- ovf_o  out  n_ch  sticky accumulator saturation flag per channel
- err_o  out  n_ch  sticky illegal-transition flag per channel

## Operation
- Decoder, per channel:
  - A and B each pass through a 2-FF synchroniser; the previous synchronised {A,B} is held.
  - Gray step 00→01→11→10→00 is +1; the reverse is −1.
  - No change gives 0.
  - A both-bits change gives 0 and sets err_o[i].
- Accumulator, per channel: signed qei_res bits.
  - Adds the decoded step.
  - Clamps at +(2^(qei_res−1)−1) and −(2^(qei_res−1)−1) and sets ovf_o[i] when a step is lost to clamping.
- Window counter: 0..P−1, advances while en=1. Tick occurs when count = P−1; the counter wraps to 0.
- On tick:
  - The accumulator value plus the current-cycle step is added to the average sum (qei_res+avg_log2 bits, signed).
  - The accumulator reloads with 0. A step decoded in the tick cycle belongs to the closing window, so no count is lost or doubled.
- The window index counts 0..2^avg_log2−1. On the tick that completes the last window:
  - result = sum >>> avg_log2 (arithmetic, rounding toward −∞).
  - If speed_res < qei_res, the result is saturated to speed_res; otherwise it is sign-extended.
  - The result is registered into speed_o for all channels at once, the sum clears, and valid_o pulses.
- en=0:
  - The window counter, accumulators, average sums and outputs hold.
  - The synchronisers and the previous-state registers keep tracking, so re-enable produces no spurious step; steps while disabled are discarded.
- clr:
  - Zeroes the counters, accumulators, sums, speed_o, ovf_o and err_o; valid_o is forced to 0.
  - The synchronisers and previous-state registers keep tracking.
  - clr has priority over en and tick.
- Flags clear only on rst or clr.

## Timing
- Reset values: speed_o=0, valid_o=0, ovf_o=0, err_o=0; window counter, index, accumulators, sums and synchroniser/previous-state registers = 0.
- Reset may assert at any time, mid-window included, and takes effect immediately. The first window after deassertion starts at count 0.
- Pin edge to accumulator: the edge is decoded in the 3rd clk after it is sampled by the first synchroniser flop.
- speed_o and valid_o are both registered and change in the cycle after the final tick; valid_o is high for exactly 1 cycle.
- Valid period = P·2^avg_log2 enabled cycles.
- Maximum decode rate is one step per clk per channel; faster inputs show up as err_o.

## Structure
- The shared config header provides `CLK_FREQ, `PID_SPEED_FREQ, `QEI_RES and `PID_RES.
- Local constants: P, and the counter width $clog2(P).
- Sub-module qei_decoder: synchroniser plus x4 decode, outputs step_up, step_dn and err pulses. It is instantiated n_ch times by generate.
- The accumulators, averaging and window counter live in the top module.

## Test plan
- clk_freq=1000, sample_freq=100 (P=10), avg_log2=0: 7 forward steps on ch0 inside one window → speed_o ch0 = 7, ch1 = 0, valid_o pulses once per 10 cycles.
- 5 reverse steps on ch1, with the last step decoded in the tick cycle → ch1 = −5 in that window, and the next window reads 0.
- A and B toggled simultaneously on ch0 → err_o[0]=1, no count change; clr → err_o=0.
- qei_res=4, 9 forward steps in one window → accumulator clamps at 7, ovf_o=1, speed_o=7.
- avg_log2=2, windows of 3, 4, 5, −1 steps → speed_o = 11>>>2 = 2, valid every 40 cycles; windows of −1 ×4 → −1.
- rst asserted mid-window while steps are arriving → all outputs 0 immediately; first valid_o exactly P cycles after deassertion. en=0 for 25 cycles → no valid_o and outputs held.
